// File: rtl/recv_filter_fifo_pkg.sv
// Shared constants and types for the receive filter FIFO: event modes,
// default reject codes for 8-bit words, and the per-capture action classification.
package recv_filter_fifo_pkg;

  localparam int EVT_TOGGLE = 0;
  localparam int EVT_EDGE   = 1;

  // Entry 0 sits in the low byte: {FA,AA,EE,FE,00,FF}.
  localparam logic [47:0] REJ_CODES_DEF = 48'hFAAAEEFE00FF;

  typedef enum logic [1:0] {
    CAP_IDLE,
    CAP_WRITE,
    CAP_REJECT,
    CAP_DROP
  } cap_action_e;

endpackage

// File: rtl/recv_filter_fifo_fifo.sv
// First-word fall-through FIFO with occupancy count; a push while full is
// accepted only when a pop in the same cycle frees the head slot.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             wr_o,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic [AW:0]      fill_o
);

  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   FILL_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      fill_q, fill_d;
  logic             full, empty, wr, rd;

  assign full  = (fill_q == FULL_LVL);
  assign empty = (fill_q == '0);
  assign rd    = pop_i & ~empty;
  assign wr    = push_i & (~full | rd);

  always_comb begin
    wr_ptr_d = wr ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = rd ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    fill_d   = fill_q;
    if (wr && !rd)      fill_d = fill_q + FILL_ONE;
    else if (rd && !wr) fill_d = fill_q - FILL_ONE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage is not reset; the head is masked while empty so stale data never shows.
  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty ? '0 : mem_q[rd_ptr_q];
  assign wr_o    = wr;
  assign empty_o = empty;
  assign fill_o  = fill_q;

endmodule

// File: rtl/recv_filter_fifo.sv
// Receive front-end: synchronises a foreign-domain event, captures the held
// data word, drops control/idle codes and buffers the rest for the display path.
module recv_filter_fifo
  import recv_filter_fifo_pkg::*;
#(
  parameter int                        WIDTH     = 8,
  parameter int                        DEPTH     = 16,
  parameter int                        EVT_MODE  = EVT_TOGGLE,
  parameter int                        NUM_REJ   = 6,
  parameter logic [NUM_REJ*WIDTH-1:0]  REJ_CODES = REJ_CODES_DEF,
  parameter int                        CNT_W     = 16,
  localparam int                       AW        = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ev_in,
  input  logic [WIDTH-1:0] din,
  input  logic             flt_en,
  input  logic             clr_cnt,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] last_data,
  output logic [AW:0]      fill,
  output logic [CNT_W-1:0] rej_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s1_q, s2_q, s3_q;
  logic             det;
  logic [WIDTH-1:0] cap_data_q;
  logic             cap_vld_q;
  logic [WIDTH-1:0] last_data_q;
  logic [CNT_W-1:0] rej_cnt_q, rej_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [NUM_REJ-1:0] code_match;
  logic             hit, fifo_wr, fifo_empty;
  cap_action_e      action;

  assign det = (EVT_MODE == EVT_TOGGLE) ? (s2_q ^ s3_q) : (s2_q & ~s3_q);

  for (genvar i = 0; i < NUM_REJ; i++) begin : g_rej
    assign code_match[i] = (cap_data_q == REJ_CODES[i*WIDTH +: WIDTH]);
  end

  assign hit = flt_en & (|code_match);

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (nRST),
    .push_i  (cap_vld_q & ~hit),
    .pop_i   (out_ready),
    .wdata_i (cap_data_q),
    .wr_o    (fifo_wr),
    .rdata_o (out_data),
    .empty_o (fifo_empty),
    .fill_o  (fill)
  );

  // A captured word that is neither rejected nor written was lost to a full FIFO.
  always_comb begin
    action = CAP_IDLE;
    if (cap_vld_q) begin
      if (hit)          action = CAP_REJECT;
      else if (fifo_wr) action = CAP_WRITE;
      else              action = CAP_DROP;
    end
  end

  always_comb begin
    rej_cnt_d  = rej_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_cnt) begin
      rej_cnt_d  = '0;
      drop_cnt_d = '0;
    end else begin
      if (action == CAP_REJECT && rej_cnt_q != '1)  rej_cnt_d  = rej_cnt_q + CNT_ONE;
      if (action == CAP_DROP   && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_ONE;
    end
  end

  // din is only sampled on the detected event; the source holds it long enough.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      cap_data_q  <= '0;
      cap_vld_q   <= 1'b0;
      last_data_q <= '0;
      rej_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      s1_q       <= ev_in;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      cap_vld_q  <= det;
      if (det) cap_data_q <= din;
      if (action == CAP_WRITE) last_data_q <= cap_data_q;
      rej_cnt_q  <= rej_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out_valid = ~fifo_empty;
  assign last_data = last_data_q;
  assign rej_cnt   = rej_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_recv_filter_fifo.sv
// Directed bench for recv_filter_fifo: toggle-mode instance with a scoreboard
// queue of expected words, plus a small edge-mode instance with 2-bit counters.
module tb_recv_filter_fifo;

  logic       CLK, nRST;

  logic       evT, fltT, clrT, readyT, validT;
  logic [7:0] dinT, outT, lastT;
  logic [4:0] fillT;
  logic [15:0] rejT, dropT;

  logic       evE, fltE, clrE, readyE, validE;
  logic [7:0] dinE, outE, lastE;
  logic [2:0] fillE;
  logic [1:0] rejE, dropE;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] expQ [$];
  int         expDrop;
  logic [7:0] rejList [6] = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

  recv_filter_fifo dutT (
    .CLK(CLK), .nRST(nRST), .ev_in(evT), .din(dinT), .flt_en(fltT), .clr_cnt(clrT),
    .out_valid(validT), .out_data(outT), .out_ready(readyT), .last_data(lastT),
    .fill(fillT), .rej_cnt(rejT), .drop_cnt(dropT)
  );

  recv_filter_fifo #(.WIDTH(8), .DEPTH(4), .EVT_MODE(1), .CNT_W(2)) dutE (
    .CLK(CLK), .nRST(nRST), .ev_in(evE), .din(dinE), .flt_en(fltE), .clr_cnt(clrE),
    .out_valid(validE), .out_data(outE), .out_ready(readyE), .last_data(lastE),
    .fill(fillE), .rej_cnt(rejE), .drop_cnt(dropE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit isRej(input logic [7:0] d);
    foreach (rejList[i]) if (rejList[i] == d) return 1'b1;
    return 1'b0;
  endfunction

  // Sends one toggle-mode word and records the expected outcome (no concurrent pops).
  task automatic applyStimulus(input logic [7:0] d);
    if (!(fltT && isRej(d))) begin
      if (expQ.size() < 16) expQ.push_back(d);
      else expDrop++;
    end
    dinT = d;
    evT  = ~evT;
    repeat (6) @(negedge CLK);
  endtask

  task automatic drainCheck(input string tag);
    int guard = 0;
    while (validT === 1'b1 && guard < 40) begin
      if (expQ.size() == 0) begin
        checkOutput({tag, "_extra"}, {31'd0, validT}, 32'd0);
        break;
      end
      checkOutput(tag, outT, expQ.pop_front());
      readyT = 1'b1;
      @(negedge CLK);
      guard++;
    end
    readyT = 1'b0;
    checkOutput({tag, "_left"}, expQ.size(), 32'd0);
  endtask

  task automatic pulseE(input logic [7:0] d, input int high);
    dinE = d;
    evE  = 1'b1;
    repeat (high) @(negedge CLK);
    evE  = 1'b0;
    repeat (6) @(negedge CLK);
  endtask

  initial begin
    nRST = 1'b0; evT = 0; dinT = 0; fltT = 1; clrT = 0; readyT = 0;
    evE = 0; dinE = 0; fltE = 0; clrE = 0; readyE = 0;
    expDrop = 0;
    repeat (3) @(negedge CLK);
    checkOutput("rst_valid", {31'd0, validT}, 32'd0);
    checkOutput("rst_data", outT, 32'd0);
    checkOutput("rst_fill", fillT, 32'd0);
    checkOutput("rst_rej", rejT, 32'd0);
    checkOutput("rst_drop", dropT, 32'd0);
    checkOutput("rst_last", lastT, 32'd0);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);

    // Latency: write lands on the 4th edge after the toggle.
    dinT = 8'h41;
    evT  = ~evT;
    repeat (3) @(posedge CLK);
    #1 checkOutput("lat_edge3", {31'd0, validT}, 32'd0);
    @(posedge CLK);
    #1 checkOutput("lat_edge4", {31'd0, validT}, 32'd1);
    @(negedge CLK);
    expQ.push_back(8'h41);
    checkOutput("lat_last", lastT, 32'h41);
    checkOutput("lat_fill", fillT, 32'd1);
    drainCheck("lat_pop");

    // Filter on then off.
    applyStimulus(8'hFA);
    applyStimulus(8'h00);
    checkOutput("flt_rej", rejT, 32'd2);
    checkOutput("flt_fill", fillT, 32'd0);
    fltT = 1'b0;
    applyStimulus(8'hFA);
    applyStimulus(8'h00);
    checkOutput("nof_fill", fillT, 32'd2);
    checkOutput("nof_rej", rejT, 32'd2);
    drainCheck("nof_pop");
    clrT = 1'b1;
    @(negedge CLK);
    clrT = 1'b0;
    checkOutput("clr_rej", rejT, 32'd0);

    // Overflow: 20 words into 16 slots.
    fltT = 1'b1;
    for (int i = 1; i <= 20; i++) applyStimulus(8'(i));
    checkOutput("ovf_fill", fillT, 32'd16);
    checkOutput("ovf_drop", dropT, 32'd4);
    checkOutput("ovf_last", lastT, 32'h14 - 32'd4);

    // Full with coincident pop: new word accepted, occupancy unchanged.
    dinT = 8'h55;
    evT  = ~evT;
    repeat (3) @(negedge CLK);
    checkOutput("fp_head", outT, expQ.pop_front());
    readyT = 1'b1;
    @(negedge CLK);
    readyT = 1'b0;
    expQ.push_back(8'h55);
    checkOutput("fp_fill", fillT, 32'd16);
    checkOutput("fp_drop", dropT, 32'd4);
    checkOutput("fp_last", lastT, 32'h55);
    drainCheck("fp_pop");

    // Ready while empty must not move pointers.
    readyT = 1'b1;
    repeat (3) @(negedge CLK);
    readyT = 1'b0;
    checkOutput("idle_fill", fillT, 32'd0);
    applyStimulus(8'h77);
    checkOutput("idle_fill1", fillT, 32'd1);
    drainCheck("idle_pop");

    // Reset mid-run.
    applyStimulus(8'hFA);
    for (int i = 0; i < 5; i++) applyStimulus(8'hA1 + 8'(i));
    checkOutput("mr_fill", fillT, 32'd5);
    checkOutput("mr_rej", rejT, 32'd1);
    nRST = 1'b0;
    evT  = 1'b0;
    #1;
    checkOutput("mr_valid", {31'd0, validT}, 32'd0);
    checkOutput("mr_fill0", fillT, 32'd0);
    checkOutput("mr_rej0", rejT, 32'd0);
    checkOutput("mr_drop0", dropT, 32'd0);
    checkOutput("mr_last0", lastT, 32'd0);
    checkOutput("mr_data0", outT, 32'd0);
    expQ.delete();
    @(negedge CLK);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);

    // Edge mode: short pulse, then a long hold, each one word.
    pulseE(8'h33, 6);
    checkOutput("edge_fill1", fillE, 32'd1);
    checkOutput("edge_data", outE, 32'h33);
    dinE = 8'h44;
    evE  = 1'b1;
    repeat (100) @(negedge CLK);
    checkOutput("edge_hold", fillE, 32'd2);
    evE = 1'b0;
    repeat (8) @(negedge CLK);
    checkOutput("edge_fall", fillE, 32'd2);
    checkOutput("edge_last", lastE, 32'h44);

    // 2-bit reject counter saturates at 3.
    fltE = 1'b1;
    for (int i = 0; i < 5; i++) pulseE(8'hFF, 5);
    checkOutput("sat_rej", rejE, 32'd3);
    checkOutput("sat_fill", fillE, 32'd2);
    clrE = 1'b1;
    @(negedge CLK);
    clrE = 1'b0;
    checkOutput("sat_clr", rejE, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
